// File: rtl/tx_pcs_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tx_pcs_encoder
// Brief    : 1000BASE-X transmit PCS: idle/packet ordered sets + 8b/10b data.
// Revision : 1.0
// ============================================================================
module tx_pcs_encoder (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    output logic [9:0] tx_code_group,
    output logic       tx_even
);

    // Special groups stored in their RD- form; RD+ form is the complement
    // except for D16.2, which keeps its balanced 4b half.
    localparam logic [9:0] c_K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] c_S_NEG     = 10'b1101101000;
    localparam logic [9:0] c_T_NEG     = 10'b1011101000;
    localparam logic [9:0] c_R_NEG     = 10'b1110101000;
    localparam logic [9:0] c_V_NEG     = 10'b0111101000;
    localparam logic [9:0] c_D16_2_POS = 10'b1001000101;
    localparam logic [9:0] c_D5_6      = 10'b1010010110;

    typedef enum logic [2:0] {
        IDLE_K = 3'd0,
        IDLE_D = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        END_T  = 3'd4,
        END_R  = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_rd;
    logic       w_rd_nxt;
    logic       r_even;
    logic [9:0] r_code;
    logic [9:0] w_code_nxt;

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [5:0] w_6n;
    logic [5:0] w_6;
    logic       w_6_unbal;
    logic       w_rd6;
    logic       w_a7;
    logic [3:0] w_4n;
    logic [3:0] w_4;
    logic       w_4_unbal;
    logic       w_rd_data;

    function automatic logic [5:0] f_enc6_neg(input logic [4:0] x);
        logic [5:0] v;
        case (x)
            5'd0:  v = 6'b100111;
            5'd1:  v = 6'b011101;
            5'd2:  v = 6'b101101;
            5'd3:  v = 6'b110001;
            5'd4:  v = 6'b110101;
            5'd5:  v = 6'b101001;
            5'd6:  v = 6'b011001;
            5'd7:  v = 6'b111000;
            5'd8:  v = 6'b111001;
            5'd9:  v = 6'b100101;
            5'd10: v = 6'b010101;
            5'd11: v = 6'b110100;
            5'd12: v = 6'b001101;
            5'd13: v = 6'b101100;
            5'd14: v = 6'b011100;
            5'd15: v = 6'b010111;
            5'd16: v = 6'b011011;
            5'd17: v = 6'b100011;
            5'd18: v = 6'b010011;
            5'd19: v = 6'b110010;
            5'd20: v = 6'b001011;
            5'd21: v = 6'b101010;
            5'd22: v = 6'b011010;
            5'd23: v = 6'b111010;
            5'd24: v = 6'b110011;
            5'd25: v = 6'b100110;
            5'd26: v = 6'b010110;
            5'd27: v = 6'b110110;
            5'd28: v = 6'b001110;
            5'd29: v = 6'b101110;
            5'd30: v = 6'b011110;
            default: v = 6'b101011;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] f_enc4_neg(input logic [2:0] y);
        logic [3:0] v;
        case (y)
            3'd0: v = 4'b1011;
            3'd1: v = 4'b1001;
            3'd2: v = 4'b0101;
            3'd3: v = 4'b1100;
            3'd4: v = 4'b1101;
            3'd5: v = 4'b1010;
            3'd6: v = 4'b0110;
            default: v = 4'b1110;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] f_ones(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Unbalanced sub-blocks flip RD; D.7 and D.x.3 are balanced but still
    // take the complemented form under RD+.
    always_comb begin
        w_x       = TXD[4:0];
        w_y       = TXD[7:5];
        w_6n      = f_enc6_neg(w_x);
        w_6_unbal = (f_ones(w_6n) != 3'd3);
        w_6       = (r_rd && (w_6_unbal || w_x == 5'd7)) ? ~w_6n : w_6n;
        w_rd6     = w_6_unbal ? ~r_rd : r_rd;
        w_a7      = (!w_rd6 && (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20)) ||
                    ( w_rd6 && (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14));
        w_4n      = (w_y == 3'd7 && w_a7) ? 4'b0111 : f_enc4_neg(w_y);
        w_4_unbal = (f_ones({2'b00, w_4n}) != 3'd2);
        w_4       = (w_rd6 && (w_4_unbal || w_y == 3'd3)) ? ~w_4n : w_4n;
        w_rd_data = w_4_unbal ? ~w_rd6 : w_rd6;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_rd_nxt    = r_rd;
        case (r_state)
            IDLE_K: begin
                // K28.5 left RD pos only if it was neg before: that case needs D16.2.
                w_state_nxt = IDLE_D;
                w_code_nxt  = r_rd ? c_D16_2_POS : c_D5_6;
                w_rd_nxt    = 1'b0;
            end
            IDLE_D: begin
                if (TX_EN) begin
                    w_state_nxt = START;
                    w_code_nxt  = r_rd ? ~c_S_NEG : c_S_NEG;
                end else begin
                    w_state_nxt = IDLE_K;
                    w_code_nxt  = r_rd ? ~c_K28_5_NEG : c_K28_5_NEG;
                    w_rd_nxt    = ~r_rd;
                end
            end
            START, DATA: begin
                if (TX_EN) begin
                    w_state_nxt = DATA;
                    if (TX_ER) begin
                        w_code_nxt = r_rd ? ~c_V_NEG : c_V_NEG;
                    end else begin
                        w_code_nxt = {w_6, w_4};
                        w_rd_nxt   = w_rd_data;
                    end
                end else begin
                    w_state_nxt = END_T;
                    w_code_nxt  = r_rd ? ~c_T_NEG : c_T_NEG;
                end
            end
            END_T: begin
                w_state_nxt = END_R;
                w_code_nxt  = r_rd ? ~c_R_NEG : c_R_NEG;
            end
            END_R: begin
                if (r_even) begin
                    w_code_nxt = r_rd ? ~c_R_NEG : c_R_NEG;
                end else begin
                    w_state_nxt = IDLE_K;
                    w_code_nxt  = r_rd ? ~c_K28_5_NEG : c_K28_5_NEG;
                    w_rd_nxt    = ~r_rd;
                end
            end
            default: begin
                w_state_nxt = IDLE_K;
                w_code_nxt  = r_rd ? ~c_K28_5_NEG : c_K28_5_NEG;
                w_rd_nxt    = ~r_rd;
            end
        endcase
    end

    always_ff @(negedge CLK) begin
        if (RESET) begin
            r_state <= IDLE_K;
            r_code  <= c_K28_5_NEG;
            r_rd    <= 1'b1;
            r_even  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_rd    <= w_rd_nxt;
            r_even  <= ~r_even;
        end
    end

    assign tx_code_group = r_code;
    assign tx_even       = r_even;

endmodule
`default_nettype wire
